// File: rtl/io_map_pkg.sv
// Address map shared by the MMIO peripheral block.
// Offsets are byte offsets inside the 256-byte window whose upper bits
// equal IO_BASE (CPU addresses 0x0000ff00-0x0000ffff).
package io_map_pkg;

  localparam logic [23:0] IO_BASE      = 24'h0000ff;

  localparam logic [7:0]  IO_LED       = 8'h00;
  localparam logic [7:0]  IO_SW        = 8'h04;
  localparam logic [7:0]  IO_OUT_READY = 8'h08;
  localparam logic [7:0]  IO_OUT_DATA  = 8'h0c;
  localparam logic [7:0]  IO_IN_VALID  = 8'h10;
  localparam logic [7:0]  IO_IN_DATA   = 8'h14;
  localparam logic [7:0]  IO_CYCLE     = 8'h18;

endpackage

// File: rtl/io_debounce.sv
// Button conditioner: two-flop synchronizer, stable-sample counter and a
// registered one-cycle pulse when the accepted level rises (a "press").
// A new level is accepted only after DEBOUNCE_CYCLES consecutive
// synchronized samples that differ from the current accepted level.
module io_debounce
  import io_map_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  // Bring the raw asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive differing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_press <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/io_periph.sv
// MMIO peripheral block: LEDs, switches, a button-driven input channel,
// a 7-seg output channel with busy/ready handshake and a cycle counter.
// Loads return io_din combinationally from io_addr; stores and the
// IN_DATA read-clear take effect on the rising clock edge.
// Build option: define IO_IRQ_EN to add the registered irq output.
module io_periph
  import io_map_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int OUT_BUSY_CYCLES = 4,
  parameter int SW_W            = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      io_addr,
  input  logic [31:0]     io_dout,
  input  logic            io_we,
  input  logic            io_rd,
  output logic [31:0]     io_din,
  input  logic [SW_W-1:0] sw,
  input  logic            btn,
  output logic [SW_W-1:0] led,
  output logic [31:0]     seg_data
`ifdef IO_IRQ_EN
  ,
  output logic            irq
`endif
);

  localparam int BW = $clog2(OUT_BUSY_CYCLES + 1);

  logic [SW_W-1:0] r_led;
  logic [31:0]     r_seg;
  logic            r_outReady;
  logic [BW-1:0]   r_busyCnt;
  logic [SW_W-1:0] r_swMeta;
  logic [SW_W-1:0] r_swSync;
  logic            r_inValid;
  logic [SW_W-1:0] r_inData;
  logic [31:0]     r_cycle;

  logic            w_press;
  logic            w_outAccept;
  logic            w_inClear;

  assign w_outAccept = io_we && (io_addr == IO_OUT_DATA) && r_outReady;
  assign w_inClear   = io_rd && (io_addr == IO_IN_DATA);

  io_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (btn),
    .o_press(w_press)
  );

  // Two-flop synchronizer for the asynchronous switch bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_swMeta <= '0;
      r_swSync <= '0;
    end else begin
      r_swMeta <= sw;
      r_swSync <= r_swMeta;
    end
  end

  // LED register loads on any store to its offset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led <= '0;
    end else if (io_we && (io_addr == IO_LED)) begin
      r_led <= io_dout[SW_W-1:0];
    end
  end

  // Output channel: an accepted store latches the display value and holds ready low for the busy window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg      <= '0;
      r_outReady <= 1'b1;
      r_busyCnt  <= '0;
    end else if (w_outAccept) begin
      r_seg      <= io_dout;
      r_outReady <= 1'b0;
      r_busyCnt  <= BW'(OUT_BUSY_CYCLES);
    end else if (!r_outReady) begin
      if (r_busyCnt <= BW'(1)) begin
        r_outReady <= 1'b1;
        r_busyCnt  <= '0;
      end else begin
        r_busyCnt <= r_busyCnt - 1'b1;
      end
    end
  end

  // Input channel: a press captures the switches unless data is already pending; a press beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inValid <= 1'b0;
      r_inData  <= '0;
    end else if (w_press && (!r_inValid || w_inClear)) begin
      r_inValid <= 1'b1;
      r_inData  <= r_swSync;
    end else if (w_inClear && !w_press) begin
      r_inValid <= 1'b0;
    end
  end

  // Free-running cycle counter; any store to its offset restarts it from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle <= '0;
    end else if (io_we && (io_addr == IO_CYCLE)) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  // Load data mux; unmapped and unaligned offsets read as zero.
  always_comb begin
    io_din = 32'd0;
    case (io_addr)
      IO_LED:       io_din = 32'(r_led);
      IO_SW:        io_din = 32'(r_swSync);
      IO_OUT_READY: io_din = {31'd0, r_outReady};
      IO_IN_VALID:  io_din = {31'd0, r_inValid};
      IO_IN_DATA:   io_din = 32'(r_inData);
      IO_CYCLE:     io_din = r_cycle;
      default:      io_din = 32'd0;
    endcase
  end

  assign led      = r_led;
  assign seg_data = r_seg;

`ifdef IO_IRQ_EN
  logic r_irq;
  logic r_outReadyDly;

  // Interrupt while input data is pending, plus one cycle when the output channel becomes ready again.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq         <= 1'b0;
      r_outReadyDly <= 1'b1;
    end else begin
      r_outReadyDly <= r_outReady;
      r_irq         <= r_inValid | (r_outReady & ~r_outReadyDly);
    end
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_io_periph.sv
// Directed bench for io_periph: register map, output handshake, debounced
// input channel with overrun and press/clear collision, cycle counter and
// mid-operation reset. Checks irq too when IO_IRQ_EN is defined.
module tb_io_periph;

  logic        clk;
  logic        rst;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we;
  logic        io_rd;
  logic [31:0] io_din;
  logic [15:0] sw;
  logic        btn;
  logic [15:0] led;
  logic [31:0] seg_data;
`ifdef IO_IRQ_EN
  logic        irq;
`endif

  int checkCount = 0;
  int errorCount = 0;
  int pressCount = 0;

  io_periph #(
    .DEBOUNCE_CYCLES(16),
    .OUT_BUSY_CYCLES(4),
    .SW_W(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .io_addr (io_addr),
    .io_dout (io_dout),
    .io_we   (io_we),
    .io_rd   (io_rd),
    .io_din  (io_din),
    .sw      (sw),
    .btn     (btn),
    .led     (led),
    .seg_data(seg_data)
`ifdef IO_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  // 20 ns clock so several combinational reads fit between edges.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Count debounced press pulses seen by the core.
  always @(posedge clk) begin
    if (!rst && dut.u_debounce.o_press) pressCount++;
  end

  // Hard stop in case a wait never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [31:0] d, input logic we, input logic rd);
    io_addr = a;
    io_dout = d;
    io_we   = we;
    io_rd   = rd;
    @(posedge clk);
    #1;
    io_we = 1'b0;
    io_rd = 1'b0;
  endtask

  task automatic busRead(input string tag, input logic [7:0] a, input logic [31:0] exp);
    io_addr = a;
    #1;
    checkOutput(tag, io_din, exp);
  endtask

  task automatic holdButton(input logic level, input int n);
    btn = level;
    tick(n);
  endtask

  initial begin
    bit found;
    rst = 1'b1; io_addr = 8'h00; io_dout = 32'd0; io_we = 1'b0; io_rd = 1'b0;
    sw = 16'h0000; btn = 1'b0;
    tick(2);
    rst = 1'b0;

    // Reset state and counter start
    checkOutput("rstLed", 32'(led), 32'h0);
    checkOutput("rstSeg", seg_data, 32'h0);
    busRead("rdLed0", 8'h00, 32'h0);
    busRead("rdReady0", 8'h08, 32'h1);
    busRead("rdValid0", 8'h10, 32'h0);
    busRead("rdInData0", 8'h14, 32'h0);
    busRead("rdCycle0", 8'h18, 32'h0);
    tick(1);
    busRead("rdCycle1", 8'h18, 32'h1);
`ifdef IO_IRQ_EN
    checkOutput("rstIrq", 32'(irq), 32'h0);
`endif

    // Unmapped offsets
    busRead("rdUnmapped", 8'h1c, 32'h0);
    busRead("rdUnaligned", 8'h01, 32'h0);
    applyStimulus(8'h1c, 32'h0000dead, 1'b1, 1'b0);
    checkOutput("unmapLed", 32'(led), 32'h0);
    checkOutput("unmapSeg", seg_data, 32'h0);
    busRead("unmapReady", 8'h08, 32'h1);

    // LEDs and switches
    applyStimulus(8'h00, 32'h0001a5a5, 1'b1, 1'b0);
    checkOutput("ledPort", 32'(led), 32'h0000a5a5);
    busRead("ledRead", 8'h00, 32'h0000a5a5);
    sw = 16'h1234;
    tick(3);
    busRead("swRead", 8'h04, 32'h00001234);

    // Output handshake: four busy cycles, dropped write while busy
    applyStimulus(8'h0c, 32'hcafef00d, 1'b1, 1'b0);
    checkOutput("segLoad", seg_data, 32'hcafef00d);
    busRead("busy1", 8'h08, 32'h0);
    busRead("outDataRead", 8'h0c, 32'h0);
    applyStimulus(8'h0c, 32'h00000001, 1'b1, 1'b0);
    checkOutput("segDropped", seg_data, 32'hcafef00d);
    busRead("busy2", 8'h08, 32'h0);
    tick(1);
    busRead("busy3", 8'h08, 32'h0);
    tick(1);
    busRead("busy4", 8'h08, 32'h0);
    tick(1);
    busRead("readyAgain", 8'h08, 32'h1);

    // Bouncy press captures switches exactly once
    sw = 16'h00ff;
    tick(3);
    for (int i = 0; i < 5; i++) holdButton((i % 2) == 0, 1);
    holdButton(1'b1, 20);
    checkOutput("pressCount1", 32'(pressCount), 32'd1);
    busRead("validAfterPress", 8'h10, 32'h1);
    busRead("dataAfterPress", 8'h14, 32'h000000ff);
    holdButton(1'b0, 25);

    // Overrun keeps the first value
    sw = 16'h0f0f;
    tick(3);
    holdButton(1'b1, 25);
    checkOutput("pressCount2", 32'(pressCount), 32'd2);
    busRead("overrunData", 8'h14, 32'h000000ff);
    busRead("overrunValid", 8'h10, 32'h1);
    holdButton(1'b0, 25);

    // Read of IN_DATA clears valid
    io_addr = 8'h14; io_rd = 1'b1;
    #1;
    checkOutput("clearReadData", io_din, 32'h000000ff);
    tick(1);
    io_rd = 1'b0;
    busRead("validCleared", 8'h10, 32'h0);

    // Press coincident with a clear: press wins
    sw = 16'h00aa;
    tick(3);
    holdButton(1'b1, 25);
    busRead("preCollideData", 8'h14, 32'h000000aa);
    holdButton(1'b0, 25);
    sw = 16'h0055;
    tick(3);
    btn = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick(1);
      if (dut.u_debounce.o_press) found = 1'b1;
    end
    checkOutput("pressSeen", 32'(found), 32'h1);
    io_addr = 8'h14; io_rd = 1'b1;
    #1;
    checkOutput("collideOldData", io_din, 32'h000000aa);
    tick(1);
    io_rd = 1'b0;
    busRead("collideValid", 8'h10, 32'h1);
    busRead("collideData", 8'h14, 32'h00000055);
`ifdef IO_IRQ_EN
    tick(1);
    checkOutput("irqPending", 32'(irq), 32'h1);
`endif
    holdButton(1'b0, 25);

    // Cycle counter restart
    applyStimulus(8'h18, 32'h12345678, 1'b1, 1'b0);
    busRead("cycleT1", 8'h18, 32'h0);
    tick(1);
    busRead("cycleT2", 8'h18, 32'h1);
    tick(5);
    busRead("cycleT7", 8'h18, 32'h6);

    // Reset in the middle of a busy countdown
    applyStimulus(8'h0c, 32'h00000077, 1'b1, 1'b0);
    busRead("busyBeforeRst", 8'h08, 32'h0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    busRead("readyAfterRst", 8'h08, 32'h1);
    busRead("cycleAfterRst", 8'h18, 32'h0);
    busRead("validAfterRst", 8'h10, 32'h0);
    checkOutput("segAfterRst", seg_data, 32'h0);
    checkOutput("ledAfterRst", 32'(led), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
